// File: rtl/network_tx_arbiter_if.sv
// AXI-Stream bundle for the TX arbiter: NUM_PORTS flattened input streams
// plus the single merged output stream toward the network_module.
interface network_tx_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64
);
  localparam int KEEP_W = DATA_WIDTH / 8;

  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*KEEP_W-1:0]     s_axis_tkeep;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [NUM_PORTS-1:0]            s_axis_tready;

  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [KEEP_W-1:0]               m_axis_tkeep;
  logic                            m_axis_tvalid;
  logic                            m_axis_tlast;
  logic                            m_axis_tready;

  // Arbiter side: sinks the requester streams, sources the merged stream.
  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  // Environment side: requesters plus the downstream network_module.
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/network_tx_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream TX sources
// onto one network_module TX port, with a 2-entry output skid and packet counters.
module network_tx_arbiter_pkt_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk156,
  input  logic                 aresetn,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  // Free-running wrap on overflow.
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn)  cnt <= '0;
    else if (inc)  cnt <= cnt + 1'b1;
  end
endmodule

module network_tx_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                           clk156,
  input  logic                           aresetn,
  network_tx_arbiter_if.slave            axis,
  output logic [NUM_PORTS-1:0]           grant,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_cnt
);
  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_W-1:0]     keep;
    logic                  last;
  } beat_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;

  logic [IDX_W-1:0]     sel_idx, cand;
  logic                 sel_found;

  logic [1:0]           occ_q;
  beat_t                slot0_q, slot1_q, in_beat;
  logic                 full, push, pop, accept, pkt_done;
  logic [NUM_PORTS-1:0] cnt_inc;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return IDX_W'(s);
  endfunction

  // Round-robin scan starting at rr_q; first valid port wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = wrap_inc(rr_q, k);
      if (!sel_found && axis.s_axis_tvalid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign in_beat.data = axis.s_axis_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
  assign in_beat.keep = axis.s_axis_tkeep[gidx_q*KEEP_W +: KEEP_W];
  assign in_beat.last = axis.s_axis_tlast[gidx_q];

  // Ready is a function of registered state only, never of m_axis_tready.
  assign full     = (occ_q == 2'd2);
  assign accept   = (state_q == BUSY) && axis.s_axis_tvalid[gidx_q] && !full;
  assign pkt_done = accept && in_beat.last;
  assign push     = accept;
  assign pop      = (occ_q != 2'd0) && axis.m_axis_tready;

  assign axis.s_axis_tready = grant_q & {NUM_PORTS{!full}};
  assign grant              = grant_q;
  assign cnt_inc            = pkt_done ? grant_q : '0;

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (sel_found) begin
          state_d = BUSY;
          gidx_d  = sel_idx;
          grant_d = NUM_PORTS'(1) << sel_idx;
        end
      end
      BUSY: begin
        // Grant held across mid-packet tvalid gaps; only tlast releases it.
        if (pkt_done) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = wrap_inc(gidx_q, 1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  // slot0 is always the head and drives m_axis directly; slot1 catches the
  // beat that was in flight when the head stalled.
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      occ_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) slot0_q <= in_beat;
          else               slot1_q <= in_beat;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          occ_q   <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            slot0_q <= in_beat;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= in_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign axis.m_axis_tvalid = (occ_q != 2'd0);
  assign axis.m_axis_tdata  = slot0_q.data;
  assign axis.m_axis_tkeep  = slot0_q.keep;
  assign axis.m_axis_tlast  = slot0_q.last;

  network_tx_arbiter_pkt_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt [NUM_PORTS-1:0] (
    .clk156  (clk156),
    .aresetn (aresetn),
    .inc     (cnt_inc),
    .cnt     (pkt_cnt)
  );
endmodule
